// File: rtl/sat_pkg.sv
// Shared types and literal helpers for the clause evaluation path.
package sat_pkg;

  localparam int unsigned NSAT_DEF  = 3;
  localparam int unsigned LIT_MAX_W = 16;
  localparam int unsigned LIT_SEL_W = $clog2(LIT_MAX_W);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE
  } feeder_state_e;

  // Width of one {neg, var_idx} literal field.
  function automatic int unsigned lit_w(input int unsigned num_vars);
    return int'($clog2(num_vars)) + 1;
  endfunction

  function automatic logic [LIT_MAX_W-1:0] lit_mask(input logic [LIT_SEL_W-1:0] var_w);
    return (LIT_MAX_W'(1) << var_w) - LIT_MAX_W'(1);
  endfunction

  function automatic logic [LIT_MAX_W-1:0] lit_pack(input logic                 neg,
                                                   input logic [LIT_MAX_W-1:0] var_idx,
                                                   input logic [LIT_SEL_W-1:0] var_w);
    logic [LIT_MAX_W-1:0] l;
    l        = var_idx & lit_mask(var_w);
    l[var_w] = neg;
    return l;
  endfunction

  function automatic logic lit_neg(input logic [LIT_MAX_W-1:0] lit,
                                   input logic [LIT_SEL_W-1:0] var_w);
    return lit[var_w];
  endfunction

  function automatic logic [LIT_MAX_W-1:0] lit_var(input logic [LIT_MAX_W-1:0] lit,
                                                   input logic [LIT_SEL_W-1:0] var_w);
    return lit & lit_mask(var_w);
  endfunction

endpackage

// File: rtl/literal_resolve.sv
// Combinational literal decode: per literal, select the assigned variable value
// and pass the negation bit through.
module literal_resolve
  import sat_pkg::*;
#(
  parameter int unsigned NSAT     = NSAT_DEF,
  parameter int unsigned NUM_VARS = 64
) (
  input  logic [NUM_VARS-1:0]             assign_i,
  input  logic [NSAT*lit_w(NUM_VARS)-1:0] cls_data_i,
  output logic [NSAT-1:0]                 val_o,
  output logic [NSAT-1:0]                 neg_o
);

  localparam int unsigned LW    = lit_w(NUM_VARS);
  localparam int unsigned VAR_W = LW - 1;

  logic [LIT_MAX_W-1:0] lit;
  logic [LIT_MAX_W-1:0] idx;

  // Out-of-range variable indices resolve to 0.
  always_comb begin
    val_o = '0;
    neg_o = '0;
    lit   = '0;
    idx   = '0;
    for (int unsigned j = 0; j < NSAT; j++) begin
      lit      = LIT_MAX_W'(cls_data_i[j*LW +: LW]);
      idx      = lit_var(lit, LIT_SEL_W'(VAR_W));
      neg_o[j] = lit_neg(lit, LIT_SEL_W'(VAR_W));
      if (idx < LIT_MAX_W'(NUM_VARS)) begin
        val_o[j] = assign_i[idx[VAR_W-1:0]];
      end
    end
  end

endmodule

// File: rtl/clause_feeder.sv
// Clause feeder: walks clause memory one clause per cycle, drives resolved
// literals to the evaluator and accumulates its break responses.
module clause_feeder
  import sat_pkg::*;
#(
  parameter int unsigned NSAT        = NSAT_DEF,
  parameter int unsigned NUM_VARS    = 64,
  parameter int unsigned NUM_CLAUSES = 256,
  parameter int unsigned EVAL_LAT    = 1
) (
  input  logic                              clk_i,
  input  logic                              reset_i,
  input  logic                              start_i,
  input  logic [$clog2(NUM_CLAUSES):0]      num_clauses_i,
  input  logic [NUM_VARS-1:0]               assign_i,
  output logic                              cls_rd_o,
  output logic [$clog2(NUM_CLAUSES)-1:0]    cls_addr_o,
  input  logic [NSAT*lit_w(NUM_VARS)-1:0]   cls_data_i,
  output logic [NSAT-1:0]                   var_val_o,
  output logic [NSAT-1:0]                   var_neg_o,
  input  logic                              break_i,
  output logic                              busy_o,
  output logic                              done_o,
  output logic                              sat_o,
  output logic [$clog2(NUM_CLAUSES):0]      unsat_count_o,
  output logic [$clog2(NUM_CLAUSES)-1:0]    first_unsat_o,
  output logic                              first_unsat_valid_o
);

  localparam int unsigned CLS_W     = $clog2(NUM_CLAUSES);
  localparam int unsigned DEPTH     = 1 + EVAL_LAT;
  localparam int unsigned DRAIN_CYC = 2 + EVAL_LAT;
  localparam int unsigned DRN_W     = $clog2(DRAIN_CYC);

  feeder_state_e state_q, state_d;

  logic [NUM_VARS-1:0] assign_q;
  logic [CLS_W:0]      n_q;
  logic [DRN_W-1:0]    drain_q;
  logic                rd_q;
  logic [CLS_W-1:0]    rd_idx_q;
  logic [DEPTH-1:0]    tag_v_q;
  logic [CLS_W-1:0]    tag_idx_q [DEPTH];
  logic [NSAT-1:0]     res_val;
  logic [NSAT-1:0]     res_neg;
  logic                start_acc;
  logic                last_issue;
  logic                drain_end;
  logic                brk_hit;

  literal_resolve #(
    .NSAT     (NSAT),
    .NUM_VARS (NUM_VARS)
  ) u_resolve (
    .assign_i   (assign_q),
    .cls_data_i (cls_data_i),
    .val_o      (res_val),
    .neg_o      (res_neg)
  );

  // Next-state decode and state-derived strobes.
  always_comb begin
    start_acc  = (state_q == IDLE) && start_i;
    last_issue = (state_q == ISSUE) && ({1'b0, cls_addr_o} == (n_q - 1'b1));
    drain_end  = (state_q == DRAIN) && (drain_q == DRN_W'(DRAIN_CYC - 1));
    brk_hit    = tag_v_q[DEPTH-1] && break_i;
    cls_rd_o   = (state_q == ISSUE);
    busy_o     = (state_q != IDLE);
    done_o     = (state_q == DONE);
    state_d    = state_q;
    case (state_q)
      IDLE:    if (start_i) state_d = (num_clauses_i == '0) ? DONE : ISSUE;
      ISSUE:   if (last_issue) state_d = DRAIN;
      DRAIN:   if (drain_end) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Pass parameters, issue address and drain timer.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      assign_q   <= '0;
      n_q        <= '0;
      cls_addr_o <= '0;
      drain_q    <= '0;
    end else begin
      if (start_acc) begin
        assign_q   <= assign_i;
        n_q        <= num_clauses_i;
        cls_addr_o <= '0;
      end else if ((state_q == ISSUE) && !last_issue) begin
        cls_addr_o <= cls_addr_o + 1'b1;
      end
      drain_q <= (state_q == DRAIN) ? drain_q + 1'b1 : '0;
    end
  end

  // Read-return tracking, decode register and clause-index tag pipe.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      rd_q      <= 1'b0;
      rd_idx_q  <= '0;
      var_val_o <= '0;
      var_neg_o <= '0;
      tag_v_q   <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) tag_idx_q[i] <= '0;
    end else begin
      rd_q     <= cls_rd_o;
      rd_idx_q <= cls_addr_o;
      if (rd_q) begin
        var_val_o <= res_val;
        var_neg_o <= res_neg;
      end
      tag_v_q[0]   <= rd_q;
      tag_idx_q[0] <= rd_idx_q;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        tag_v_q[i]   <= tag_v_q[i-1];
        tag_idx_q[i] <= tag_idx_q[i-1];
      end
    end
  end

  // Result accumulation; sat is resolved on entry to DONE so a break sampled
  // in the final drain cycle is already counted.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      unsat_count_o       <= '0;
      first_unsat_o       <= '0;
      first_unsat_valid_o <= 1'b0;
      sat_o               <= 1'b0;
    end else if (start_acc) begin
      unsat_count_o       <= '0;
      first_unsat_o       <= '0;
      first_unsat_valid_o <= 1'b0;
      sat_o               <= (num_clauses_i == '0);
    end else begin
      if (brk_hit) begin
        unsat_count_o <= unsat_count_o + 1'b1;
        if (!first_unsat_valid_o) begin
          first_unsat_o       <= tag_idx_q[DEPTH-1];
          first_unsat_valid_o <= 1'b1;
        end
      end
      if ((state_q == DRAIN) && drain_end) begin
        sat_o <= (unsat_count_o == '0) && !brk_hit;
      end
    end
  end

endmodule

// File: doc/clause_feeder.md
# clause_feeder

- Initiator side of the clause-evaluation interface.
- On `start_i` it latches a variable assignment and walks the clause memory at one clause per cycle.
- For each clause it resolves each literal's variable value and negation bit and drives them to a single clause evaluator, then collects the evaluator's `break` response.
- It reports satisfiability, the count of unsatisfied clauses and the index of the first unsatisfied clause to the solver control logic.

## Interface
- NSAT, 3, literals per clause (matches evaluator).
- NUM_VARS, 64, variables in the assignment vector.
- NUM_CLAUSES, 256, clause memory depth.
- EVAL_LAT, 1, cycles from `var_*_o` change to corresponding `break_i`; the evaluator has this latency in both gating modes.
- clk_i  in  1  single clock, rising edge.
- reset_i  in  1  asynchronous, active-low reset.
- start_i  in  1  begin a pass; sampled only in IDLE.
- num_clauses_i  in  CLS_W+1  clauses to evaluate, 0..NUM_CLAUSES; sampled with start.
- assign_i  in  NUM_VARS  variable values; latched on accepted start.
- cls_rd_o  out  1  clause memory read strobe.
- cls_addr_o  out  CLS_W  clause address.
- cls_data_i  in  NSAT*(VAR_W+1)  clause word, valid the cycle after `cls_rd_o`. Literal j occupies bits [j*(VAR_W+1) +: VAR_W+1] as {neg, var_idx}.
- var_val_o  out  NSAT  resolved literal values to evaluator.
- var_neg_o  out  NSAT  literal negation bits to evaluator.
- break_i  in  1  evaluator result (1 = clause unsatisfied).
- busy_o  out  1  pass in progress.
- done_o  out  1  one-cycle pulse at end of pass.
- sat_o  out  1  all evaluated clauses satisfied; valid from `done_o` until next accepted start.
- unsat_count_o  out  CLS_W+1  number of breaking clauses.
- first_unsat_o  out  CLS_W  lowest breaking clause index.
- first_unsat_valid_o  out  1  at least one clause broke.

VAR_W = $clog2(NUM_VARS), CLS_W = $clog2(NUM_CLAUSES).

## Operation
- FSM states:
  - IDLE → ISSUE on start_i with num_clauses_i>0.
  - IDLE → DONE on start_i with num_clauses_i==0.
  - ISSUE → DRAIN after address N-1 is issued.
  - DRAIN → DONE after 2+EVAL_LAT cycles.
  - DONE → IDLE unconditionally.
- Accepted start:
  - latches assign_i and N.
  - clears unsat_count_o, first_unsat_valid_o, first_unsat_o and sat_o.
- start_i outside IDLE is ignored; the latched assignment is not disturbed.
- ISSUE:
  - cls_rd_o=1.
  - cls_addr_o counts 0..N-1, one per cycle.
  - No stall; the memory is a fixed 1-cycle synchronous read.
- Decode stage (cycle after read):
  - var_val_o[j] <= assign_q[var_idx_j].
  - var_neg_o[j] <= neg_j.
  - The decode stage also pushes a valid bit and the clause index into the tag pipe.
- The tag pipe is 1+EVAL_LAT deep. When the pipe head is valid, break_i is sampled:
  - if break_i=1: increment unsat_count_o (no wrap; max NUM_CLAUSES fits).
  - if break_i=1 and first_unsat_valid_o=0: capture the index and set first_unsat_valid_o.
- DONE:
  - done_o=1 for one cycle.
  - sat_o <= (unsat_count==0), counting any break sampled in that same cycle.
- Outputs hold until the next accepted start.
- Short clauses are padded by repeating a literal; the feeder performs no special handling.
- var_idx ≥ NUM_VARS resolves to value 0.
- Reset (any time, including mid-pass):
  - all state and outputs go to 0, FSM to IDLE.
  - cls_rd_o drops asynchronously.
  - No done_o is produced for the aborted pass.

## Timing
- Cycle 0: start_i high in IDLE.
- Cycles 1..N: ISSUE, address k issued in cycle k+1.
- Clause k data arrives in cycle k+2; var_*_o for clause k are valid in cycle k+3.
- break_i for clause k is sampled in cycle k+3+EVAL_LAT.
- done_o is high in cycle N+3+EVAL_LAT (N+4 at default), then IDLE.
- N=0: done_o in cycle 1 with sat_o=1, cls_rd_o never asserted.
- busy_o=1 from cycle 1 through the done cycle inclusive.
- Next start is accepted the cycle after done_o.
- var_*_o hold their last value between passes; the evaluator output is ignored when the tag is invalid.

## Structure
- Shared package sat_pkg holds:
  - NSAT default.
  - literal field width function (VAR_W+1).
  - literal packing/unpacking functions.
  - the FSM state enum {IDLE, ISSUE, DRAIN, DONE}.
- Sub-module literal_resolve: NSAT parallel NUM_VARS:1 muxes plus negation pass-through. It is combinational, and its outputs are registered in clause_feeder.
- The tag pipe, counters and FSM live in clause_feeder.

## Test plan
- Vars = 8'b0000_0101, N=3, clauses {x0,x1,x2}, {¬x0,¬x2,x1}, {¬x1,¬x1,¬x1}, EVAL_LAT=1, with a behavioural evaluator. Required:
  - done_o in cycle 7.
  - unsat_count_o=1, first_unsat_o=1, first_unsat_valid_o=1, sat_o=0.
- All-satisfied pass of N=256 → done_o in cycle 260, sat_o=1, unsat_count_o=0, first_unsat_valid_o=0.
- N=0 → done_o in cycle 1, sat_o=1, no cls_rd_o pulse.
- Every clause breaks, N=256 → unsat_count_o=256 (no wrap), first_unsat_o=0.
- start_i pulsed mid-pass with different assign_i → ignored; results match the first assignment.
- reset_i low in cycle 5 of an N=10 pass → all outputs 0 immediately, no done_o; a new start after release completes normally.
